// File: rtl/ncpu32k_dbus_sram.sv
// Word-organised SRAM behind the ncpu32k data-bus handshake, responding a fixed LATENCY after accept.
// Define NCPU_DBUS_ALIGN_CHK_EN to flag misaligned halfword/word accesses instead of truncating them.
module ncpu32k_dbus_sram #(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned NCPU_AW = 32,
    parameter int unsigned NCPU_DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCPU_AW-1:0] dbus_addr_i,
    input  logic [2:0]         dbus_size_i,
    input  logic               dbus_in_valid,
    output logic               dbus_in_ready,
    input  logic [NCPU_DW-1:0] dbus_i,
    input  logic               dbus_out_ready,
    output logic               dbus_out_valid,
    output logic [NCPU_DW-1:0] dbus_o,
    output logic               dbus_err_o
);

    typedef enum logic [2:0] {
        StIdle, StRdWait, StRdResp, StWrWait, StWrResp
    } state_e;

    localparam logic [3:0] LatInit = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              accept, resp_d, bad;
    logic [MEM_AW-1:0] word_q, in_word, cur_word;
    logic [1:0]        sh_q, in_sh, cur_sh;
    logic [1:0]        szc_q, in_szc, cur_szc;  // 0 byte, 1 halfword, 2 word
    logic [3:0]        be_q, in_be;
    logic [31:0]       wdata_q, in_wdata;
    logic              misal_q, in_misal, cur_misal;
    logic [31:0]       rd_word, rd_shift, load_data, rdata_q;
    logic              in_ready_q, out_valid_q, err_q;
    logic [31:0]       mem_q [2**MEM_AW];
    logic              unused_addr;

    assign unused_addr = ^dbus_addr_i[NCPU_AW-1:MEM_AW+2];

    // Lane decode of the incoming request; store data is replicated so each lane sees its bytes.
    always_comb begin
        in_word  = dbus_addr_i[MEM_AW+1:2];
        in_szc   = 2'd2;
        in_sh    = 2'd0;
        in_be    = 4'b1111;
        in_wdata = dbus_i[31:0];
        in_misal = |dbus_addr_i[1:0];
        case (dbus_size_i)
            3'd1: begin
                in_szc   = 2'd0;
                in_sh    = dbus_addr_i[1:0];
                in_be    = 4'b0001 << dbus_addr_i[1:0];
                in_wdata = {4{dbus_i[7:0]}};
                in_misal = 1'b0;
            end
            3'd2: begin
                in_szc   = 2'd1;
                in_sh    = {dbus_addr_i[1], 1'b0};
                in_be    = dbus_addr_i[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{dbus_i[15:0]}};
                in_misal = dbus_addr_i[0];
            end
            default: ;
        endcase
    end

    // With LATENCY=1 the response is formed on the accept edge, so use the live request then.
    always_comb begin
        cur_word  = accept ? in_word : word_q;
        cur_sh    = accept ? in_sh : sh_q;
        cur_szc   = accept ? in_szc : szc_q;
        cur_misal = accept ? in_misal : misal_q;
        rd_word   = mem_q[cur_word];
        rd_shift  = rd_word >> {cur_sh, 3'b000};
        case (cur_szc)
            2'd0:    load_data = {24'h0, rd_shift[7:0]};
            2'd1:    load_data = {16'h0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

`ifdef NCPU_DBUS_ALIGN_CHK_EN
    assign bad = cur_misal;
`else
    logic unused_misal;
    assign unused_misal = cur_misal;
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (dbus_in_valid) begin
                    accept  = 1'b1;
                    cnt_d   = LatInit;
                    state_d = (LATENCY > 1) ? StWrWait : StWrResp;
                end else if (dbus_out_ready) begin
                    accept  = 1'b1;
                    cnt_d   = LatInit;
                    state_d = (LATENCY > 1) ? StRdWait : StRdResp;
                end
            end
            StWrWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = StWrResp;
            end
            StRdWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = StRdResp;
            end
            StWrResp: state_d = StIdle;
            StRdResp: if (dbus_out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign resp_d = (state_d == StWrResp) || (state_d == StRdResp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            word_q      <= '0;
            sh_q        <= '0;
            szc_q       <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            misal_q     <= 1'b0;
            rdata_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == StWrResp);
            out_valid_q <= (state_d == StRdResp);
            err_q       <= bad && resp_d;
            if (accept) begin
                word_q  <= in_word;
                sh_q    <= in_sh;
                szc_q   <= in_szc;
                be_q    <= in_be;
                wdata_q <= in_wdata;
                misal_q <= in_misal;
            end
            if (state_d == StRdResp && state_q != StRdResp) begin
                rdata_q <= bad ? 32'h0 : load_data;
            end
        end
    end

    // Contents survive reset; a store commits only on the edge that leaves WR_RESP.
    always_ff @(posedge clk) begin
        if (state_q == StWrResp && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign dbus_in_ready  = in_ready_q;
    assign dbus_out_valid = out_valid_q;
    assign dbus_o         = rdata_q;
    assign dbus_err_o     = err_q;

endmodule

// File: tb/tb_ncpu32k_dbus_sram.sv
// Randomised bench for ncpu32k_dbus_sram against a byte-array transaction model.
module tb_ncpu32k_dbus_sram;
    localparam int unsigned MemAw  = 4;
    localparam int unsigned Lat    = 3;
    localparam int unsigned NBytes = 4 << MemAw;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dbus_addr_i;
    logic [2:0]  dbus_size_i;
    logic        dbus_in_valid;
    logic        dbus_in_ready;
    logic [31:0] dbus_i;
    logic        dbus_out_ready;
    logic        dbus_out_valid;
    logic [31:0] dbus_o;
    logic        dbus_err_o;

    always #5 clk = ~clk;

    ncpu32k_dbus_sram #(
        .MEM_AW (MemAw),
        .LATENCY(Lat)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dbus_addr_i   (dbus_addr_i),
        .dbus_size_i   (dbus_size_i),
        .dbus_in_valid (dbus_in_valid),
        .dbus_in_ready (dbus_in_ready),
        .dbus_i        (dbus_i),
        .dbus_out_ready(dbus_out_ready),
        .dbus_out_valid(dbus_out_valid),
        .dbus_o        (dbus_o),
        .dbus_err_o    (dbus_err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: memory is a flat byte array, timing is "response from accept+Lat-1".
    logic [7:0]  m_bytes [NBytes];
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_wr, m_err;
    int          m_resp;
    int unsigned m_base, m_n;
    logic [31:0] m_wdata, m_rdata;

    function automatic int unsigned nbytes(input logic [2:0] s);
        return (s == 3'd1) ? 1 : (s == 3'd2) ? 2 : 4;
    endfunction

    task automatic m_accept(input bit wr);
        int unsigned a, n;
        a = dbus_addr_i % NBytes;
        n = nbytes(dbus_size_i);
        m_busy  = 1;
        m_wr    = wr;
        m_resp  = cyc + Lat - 1;
        m_err   = 0;
`ifdef NCPU_DBUS_ALIGN_CHK_EN
        m_err = (a % n) != 0;
`endif
        m_base  = a - a % n;
        m_n     = n;
        m_wdata = dbus_i;
        m_rdata = 32'h0;
        if (!wr && !m_err) begin
            for (int i = 0; i < int'(n); i++) m_rdata[8*i +: 8] = m_bytes[m_base + i];
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc > m_resp && (m_wr || dbus_out_ready)) begin
                    if (m_wr && !m_err) begin
                        for (int i = 0; i < int'(m_n); i++) m_bytes[m_base + i] = m_wdata[8*i +: 8];
                    end
                    m_busy = 0;
                end
            end else if (dbus_in_valid) begin
                m_accept(1);
            end else if (dbus_out_ready) begin
                m_accept(0);
            end
        end
    end

    initial forever begin
        bit exp_resp;
        @(negedge clk);
        exp_resp = m_busy && (cyc >= m_resp);
        chk("in_ready", 32'(dbus_in_ready), 32'(exp_resp && m_wr));
        chk("out_valid", 32'(dbus_out_valid), 32'(exp_resp && !m_wr));
        chk("err", 32'(dbus_err_o), 32'(exp_resp && m_err));
        if (exp_resp && !m_wr) chk("dbus_o", dbus_o, m_rdata);
    end

    task automatic do_store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                            input logic [31:0] nxt_a, input logic [2:0] nxt_s);
        int t0, k;
        dbus_addr_i   = a;
        dbus_size_i   = s;
        dbus_i        = d;
        dbus_in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        dbus_addr_i = nxt_a;
        dbus_size_i = nxt_s;
        dbus_i      = $urandom;
        k = 0;
        do begin @(negedge clk); k++; end while (!dbus_in_ready && k < 40);
        chk("store_hs", 32'(dbus_in_ready), 32'd1);
        @(posedge clk); #1;
        dbus_in_valid = 1'b0;
        chk("store_lat", 32'(cyc - t0), 32'(Lat));
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        do_store(a, s, d, $urandom, 3'($urandom_range(0, 7)));
    endtask

    task automatic finish_load(input int stall, output logic [31:0] d);
        int t0, k;
        t0 = cyc;
        dbus_addr_i = $urandom;
        dbus_size_i = 3'($urandom_range(0, 7));
        dbus_i      = $urandom;
        if (stall > 0) begin
            dbus_out_ready = 1'b0;
            repeat (stall) @(posedge clk);
            #1;
            dbus_out_ready = 1'b1;
        end
        k = 0;
        do begin @(negedge clk); k++; end while (!dbus_out_valid && k < 40);
        chk("load_hs", 32'(dbus_out_valid), 32'd1);
        d = dbus_o;
        @(posedge clk); #1;
        dbus_out_ready = 1'b0;
        if (stall == 0) chk("load_lat", 32'(cyc - t0), 32'(Lat));
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] s, input int stall,
                           output logic [31:0] d);
        dbus_addr_i    = a;
        dbus_size_i    = s;
        dbus_out_ready = 1'b1;
        @(posedge clk); #1;
        finish_load(stall, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, a, b;
        logic [2:0]  s;
        int unsigned op;
        rst = 1'b1;
        dbus_in_valid = 1'b0;
        dbus_out_ready = 1'b0;
        dbus_addr_i = '0;
        dbus_size_i = '0;
        dbus_i = '0;
        #1;
        chk("rst_in_ready", 32'(dbus_in_ready), 32'd0);
        chk("rst_out_valid", 32'(dbus_out_valid), 32'd0);
        chk("rst_err", 32'(dbus_err_o), 32'd0);
        chk("rst_dbus_o", dbus_o, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int w = 0; w < int'(NBytes / 4); w++) st(32'(w * 4), 3'd4, $urandom);

        st(32'h10, 3'd4, 32'hDEADBEEF);
        do_load(32'h10, 3'd4, 0, d);
        chk("lit_word", d, 32'hDEADBEEF);

        st(32'h10, 3'd4, 32'h11223344);
        st(32'h13, 3'd1, 32'hFFFFFFAA);
        do_load(32'h10, 3'd4, 0, d);
        chk("lit_byte_merge", d, 32'hAA223344);
        do_load(32'h13, 3'd1, 0, d);
        chk("lit_byte_load", d, 32'h000000AA);
        do_load(32'h12, 3'd2, 0, d);
        chk("lit_half_load", d, 32'h0000AA22);

        st(32'h13, 3'd2, 32'h1234BEEF);
        do_load(32'h10, 3'd0, 0, d);
`ifdef NCPU_DBUS_ALIGN_CHK_EN
        chk("lit_half_misal", d, 32'hAA223344);
`else
        chk("lit_half_trunc", d, 32'hBEEF3344);
`endif

        st(32'h0000_1050, 3'd4, 32'h5555AAAA);
        do_load(32'h10, 3'd4, 0, d);
        chk("lit_wrap", d, 32'h5555AAAA);

        do_load(32'h10, 3'd4, Lat + 4, d);
        chk("lit_stall", d, 32'h5555AAAA);

        dbus_out_ready = 1'b1;
        do_store(32'h24, 3'd4, 32'hCAFEF00D, 32'h24, 3'd4);
        @(posedge clk); #1;
        finish_load(0, d);
        chk("lit_both", d, 32'hCAFEF00D);

        st(32'h0, 3'd4, 32'h01020304);
        st(32'h2, 3'd4, 32'hA5A55A5A);
        do_load(32'h0, 3'd4, 0, d);
`ifdef NCPU_DBUS_ALIGN_CHK_EN
        chk("lit_word_misal", d, 32'h01020304);
`else
        chk("lit_word_trunc", d, 32'hA5A55A5A);
`endif

        // Abort a store while it is still waiting.
        st(32'h30, 3'd4, 32'h0BADF00D);
        dbus_addr_i = 32'h30;
        dbus_size_i = 3'd4;
        dbus_i = 32'h12345678;
        dbus_in_valid = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("wrst_in_ready", 32'(dbus_in_ready), 32'd0);
        chk("wrst_err", 32'(dbus_err_o), 32'd0);
        dbus_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        do_load(32'h30, 3'd4, 0, d);
        chk("lit_rst_keep", d, 32'h0BADF00D);

        // Reset while a load response is being held.
        dbus_addr_i = 32'h30;
        dbus_size_i = 3'd4;
        dbus_out_ready = 1'b1;
        @(posedge clk); #1;
        dbus_out_ready = 1'b0;
        repeat (Lat) @(negedge clk);
        chk("pre_rst_valid", 32'(dbus_out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rrst_out_valid", 32'(dbus_out_valid), 32'd0);
        chk("rrst_dbus_o", dbus_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 300; t++) begin
            a  = $urandom;
            b  = $urandom;
            s  = 3'($urandom_range(0, 7));
            op = $urandom_range(0, 3);
            case (op)
                0: st(a, s, $urandom);
                1: do_load(a, s, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0, d);
                2: begin
                    dbus_out_ready = 1'b1;
                    do_store(a, s, $urandom, b, 3'($urandom_range(0, 7)));
                    @(posedge clk); #1;
                    finish_load(0, d);
                end
                default: do_load(a, s, 0, d);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ncpu32k_dbus_sram.md
NCPU32K_DBUS_SRAM -- requirements
Module: ncpu32k_dbus_sram

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 12, meaning word-address width; memory depth is 2^MEM_AW 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning cycles from request accept to response; legal range 1..15.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, the clock (all state on rising edge).
REQ-004 The block SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-005 The block SHALL have port dbus_addr_i, input, width NCPU_AW: byte address.
REQ-006 The block SHALL have port dbus_size_i, input, width 3: access width in bytes; 1, 2 or 4.
REQ-007 The block SHALL have port dbus_in_valid, input, width 1: store data presented by initiator.
REQ-008 The block SHALL have port dbus_in_ready, output, width 1: store committed.
REQ-009 The block SHALL have port dbus_i, input, width NCPU_DW: store data, right-aligned.
REQ-010 The block SHALL have port dbus_out_ready, input, width 1: initiator requests load and is ready to take data.
REQ-011 The block SHALL have port dbus_out_valid, output, width 1: load data valid.
REQ-012 The block SHALL have port dbus_o, output, width NCPU_DW: load data, right-aligned and zero-extended.
REQ-013 The block SHALL have port dbus_err_o, output, width 1: misaligned-access error flag.

Function
REQ-014 The block SHALL implement FSM states IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
REQ-015 When IDLE and dbus_in_valid=1, the block SHALL latch addr, size and data and enter WR_WAIT; store SHALL win when dbus_in_valid and dbus_out_ready are both high.
REQ-016 When IDLE, dbus_out_ready=1 and dbus_in_valid=0, the block SHALL latch addr and size and enter RD_WAIT.
REQ-017 A 4-bit latency counter SHALL load LATENCY-1 on accept, decrement in *_WAIT, and move to *_RESP when it reads 0; for LATENCY=1, *_WAIT SHALL last 0 cycles (direct to *_RESP).
REQ-018 The response (dbus_in_ready or dbus_out_valid) SHALL be registered and asserted exactly LATENCY cycles after the accept edge.
REQ-019 In WR_RESP, dbus_in_ready SHALL be 1 for exactly one cycle, the write SHALL commit at that edge, and the FSM SHALL return to IDLE.
REQ-020 In RD_RESP, dbus_out_valid=1 and dbus_o SHALL be held stable until an edge with dbus_out_ready=1, then the FSM SHALL return to IDLE; dropping dbus_out_ready SHALL not lose data.
REQ-021 Memory SHALL be little-endian; the word index SHALL be addr[MEM_AW+1:2]; upper address bits SHALL be ignored, so addresses wrap.
REQ-022 Store lanes: size 1 SHALL write byte addr[1:0] from dbus_i[7:0]; size 2 SHALL write halfword addr[1] from dbus_i[15:0]; size 4 SHALL write the full word; other lanes SHALL be unchanged.
REQ-023 Load: selected bytes SHALL be shifted to bit 0 and zero-extended.
REQ-024 Size values 0, 3 and 5..7 SHALL be treated as size 4.
REQ-025 The minimum spacing SHALL be one IDLE cycle between consecutive transactions, and no new request SHALL be accepted outside IDLE.

Reset
REQ-026 Asserting rst SHALL force IDLE, counter 0, and dbus_in_ready, dbus_out_valid, dbus_err_o and dbus_o all to 0, asynchronously.
REQ-027 A reset mid-transaction SHALL abort it; a store not yet in WR_RESP SHALL not be written.
REQ-028 Memory contents SHALL not be reset.

Configuration
REQ-029 With macro NCPU_DBUS_ALIGN_CHK_EN defined, an access with size 2 and addr[0]!=0, or size 4 and addr[1:0]!=0, SHALL suppress the memory write, return dbus_o=0, and assert dbus_err_o together with the response cycle(s).
REQ-030 Without NCPU_DBUS_ALIGN_CHK_EN, dbus_err_o SHALL be tied 0 and misaligned addresses SHALL be truncated to size alignment.

Verification
REQ-031 LATENCY=1: store size 4, addr 0x10, data 0xDEADBEEF -> dbus_in_ready pulses 1 cycle after accept; a subsequent load size 4 at 0x10 returns 0xDEADBEEF with dbus_out_valid 1 cycle after accept.
REQ-032 Store byte 0xAA to 0x13 over word 0x11223344 -> word load reads 0xAA223344; byte load at 0x13 returns 0x000000AA.
REQ-033 LATENCY=3 with dbus_out_ready dropped during RD_RESP for 4 cycles -> dbus_out_valid and dbus_o are held, and the handshake completes when ready returns.
REQ-034 In IDLE, dbus_in_valid and dbus_out_ready asserted together -> the store is accepted first and the load follows after one IDLE cycle.
REQ-035 rst asserted in WR_WAIT (LATENCY=4) -> all outputs are 0 immediately and the target word is unchanged.
REQ-036 With NCPU_DBUS_ALIGN_CHK_EN, word store at 0x02 -> dbus_err_o=1 with dbus_in_ready and memory is unchanged; without the macro, the word at 0x00 is written.
